// File: rtl/sram_port_arbiter.sv
// Round-robin sharing of a two-port sram: up to two grants per cycle (A then B), read data returned 1 cycle after grant.
// No backpressure: requesters hold req until gnt; a same-address write hazard idles port B for that cycle.
module sram_port_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4,
    parameter int NUM_REQ    = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_REQ-1:0]             req,
    input  logic [NUM_REQ-1:0]             req_we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_wdata,
    output logic [NUM_REQ-1:0]             gnt,
    output logic [NUM_REQ-1:0]             rvalid,
    output logic [NUM_REQ*DATA_WIDTH-1:0]  rdata,
    output logic [ADDR_WIDTH-1:0]          addr_a,
    output logic [ADDR_WIDTH-1:0]          addr_b,
    output logic [DATA_WIDTH-1:0]          data_a,
    output logic [DATA_WIDTH-1:0]          data_b,
    output logic                           we_a,
    output logic                           we_b,
    input  logic [DATA_WIDTH-1:0]          q_a,
    input  logic [DATA_WIDTH-1:0]          q_b
);

    localparam int IDX_W  = $clog2(NUM_REQ);
    localparam int IDX_W1 = IDX_W + 1;

    logic [ADDR_WIDTH-1:0] addr_arr  [NUM_REQ];
    logic [DATA_WIDTH-1:0] wdata_arr [NUM_REQ];

    logic [IDX_W-1:0] rr_ptr, w1, w2, idx, last, ptr_nxt;
    logic [IDX_W-1:0] own_a_idx, own_b_idx;
    logic [IDX_W1-1:0] sum;
    logic w1_found, w2_found, hazard, grant_a, grant_b;
    logic own_a_vld, own_b_vld;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign addr_arr[g]  = req_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
        assign wdata_arr[g] = req_wdata[g*DATA_WIDTH +: DATA_WIDTH];
    end

    // Scan from rr_ptr with wrap; first two requesters found are the candidates.
    always_comb begin
        w1       = '0;
        w2       = '0;
        w1_found = 1'b0;
        w2_found = 1'b0;
        sum      = '0;
        idx      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum = {1'b0, rr_ptr} + IDX_W1'(k);
            if (sum >= IDX_W1'(NUM_REQ)) begin
                sum = sum - IDX_W1'(NUM_REQ);
            end
            idx = sum[IDX_W-1:0];
            if (req[idx]) begin
                if (!w1_found) begin
                    w1       = idx;
                    w1_found = 1'b1;
                end else if (!w2_found) begin
                    w2       = idx;
                    w2_found = 1'b1;
                end
            end
        end
    end

    assign hazard  = w2_found && (addr_arr[w1] == addr_arr[w2]) && (req_we[w1] || req_we[w2]);
    assign grant_a = rst_n && w1_found;
    assign grant_b = rst_n && w2_found && !hazard;

    always_comb begin
        gnt = '0;
        if (grant_a) gnt[w1] = 1'b1;
        if (grant_b) gnt[w2] = 1'b1;
    end

    assign addr_a = grant_a ? addr_arr[w1]  : '0;
    assign data_a = grant_a ? wdata_arr[w1] : '0;
    assign we_a   = grant_a && req_we[w1];
    assign addr_b = grant_b ? addr_arr[w2]  : '0;
    assign data_b = grant_b ? wdata_arr[w2] : '0;
    assign we_b   = grant_b && req_we[w2];

    assign last    = grant_b ? w2 : w1;
    assign ptr_nxt = (last == IDX_W'(NUM_REQ - 1)) ? '0 : last + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr    <= '0;
            own_a_vld <= 1'b0;
            own_b_vld <= 1'b0;
            own_a_idx <= '0;
            own_b_idx <= '0;
        end else begin
            if (grant_a) rr_ptr <= ptr_nxt;
            own_a_vld <= grant_a && !req_we[w1];
            own_b_vld <= grant_b && !req_we[w2];
            own_a_idx <= w1;
            own_b_idx <= w2;
        end
    end

    // Owners are always distinct requesters, so at most one port feeds each slice.
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_ret
        logic hit_a, hit_b;
        assign hit_a     = own_a_vld && (own_a_idx == IDX_W'(g));
        assign hit_b     = own_b_vld && (own_b_idx == IDX_W'(g));
        assign rvalid[g] = hit_a || hit_b;
        assign rdata[g*DATA_WIDTH +: DATA_WIDTH] = hit_a ? q_a : (hit_b ? q_b : '0);
    end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: directed vector table, reset corner sequence, randomized run against a queue-based model.
module tb_sram_port_arbiter;
    localparam int DW = 32;
    localparam int AW = 4;
    localparam int NR = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [NR-1:0] req, req_we, gnt, rvalid;
    logic [NR*AW-1:0] req_addr;
    logic [NR*DW-1:0] req_wdata, rdata;
    logic [AW-1:0] addr_a, addr_b;
    logic [DW-1:0] data_a, data_b, q_a, q_b;
    logic we_a, we_b;

    sram_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REQ(NR)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
        .addr_a(addr_a), .addr_b(addr_b), .data_a(data_a), .data_b(data_b),
        .we_a(we_a), .we_b(we_b), .q_a(q_a), .q_b(q_b)
    );

    always #5 clk = ~clk;

    // Two-port sram with 1-cycle registered read, preloaded with A0000000+addr.
    logic [DW-1:0] sram [16];
    logic init_done = 1'b0;
    always @(posedge clk) begin
        if (!init_done) begin
            for (int i = 0; i < 16; i++) sram[i] <= 32'hA000_0000 + 32'(i);
            init_done <= 1'b1;
        end else begin
            if (we_a) sram[addr_a] <= data_a;
            if (we_b) sram[addr_b] <= data_b;
        end
        q_a <= sram[addr_a];
        q_b <= sram[addr_b];
    end

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    typedef struct {
        bit           rst;
        logic [3:0]   rq, we;
        logic [15:0]  ad;
        logic [127:0] wd;
        logic [3:0]   g, aa, ab;
        logic         wea, web;
        logic [31:0]  da, db;
        logic [3:0]   rv;
        logic [127:0] rd;
    } vec_t;

    function automatic vec_t v(bit rst, logic [3:0] rq, logic [3:0] we, logic [15:0] ad,
                               logic [127:0] wd, logic [3:0] g, logic [3:0] aa, logic [3:0] ab,
                               logic wea, logic web, logic [31:0] da, logic [31:0] db,
                               logic [3:0] rv, logic [127:0] rd);
        vec_t r;
        r.rst = rst; r.rq = rq; r.we = we; r.ad = ad; r.wd = wd; r.g = g; r.aa = aa; r.ab = ab;
        r.wea = wea; r.web = web; r.da = da; r.db = db; r.rv = rv; r.rd = rd;
        return r;
    endfunction

    // Reference model state
    int ptr;
    logic [31:0] mmem [16];
    logic [3:0]  exp_rv;
    logic [31:0] exp_rd [4];
    bit          pv [4];
    bit          pw [4];
    logic [3:0]  pa [4];
    logic [31:0] pd [4];

    initial begin
        vec_t tbl [12];
        tbl[0]  = v(1, 4'b0000, 4'b0000, 16'h0000, '0, 4'b0000, 4'h0, 4'h0, 0, 0, 0, 0, 4'b0000, '0);
        tbl[1]  = v(0, 4'b0101, 4'b1111, 16'h9933,
                    {32'hBAD0BAD0, 32'h22222222, 32'hBAD0BAD0, 32'h11111111},
                    4'b0101, 4'h3, 4'h9, 1, 1, 32'h11111111, 32'h22222222, 4'b0000, '0);
        tbl[2]  = v(0, 4'b0101, 4'b0000, 16'h0903, '0, 4'b0101, 4'h3, 4'h9, 0, 0, 0, 0, 4'b0000, '0);
        tbl[3]  = v(0, 4'b0000, 4'b0000, 16'h0000, '0, 4'b0000, 4'h0, 4'h0, 0, 0, 0, 0, 4'b0101,
                    {32'h0, 32'h22222222, 32'h0, 32'h11111111});
        tbl[4]  = v(1, 4'b1111, 4'b0000, 16'h6421, '0, 4'b0011, 4'h1, 4'h2, 0, 0, 0, 0, 4'b0000, '0);
        tbl[5]  = v(0, 4'b1111, 4'b0000, 16'h6421, '0, 4'b1100, 4'h4, 4'h6, 0, 0, 0, 0, 4'b0011,
                    {32'h0, 32'h0, 32'hA0000002, 32'hA0000001});
        tbl[6]  = v(0, 4'b1111, 4'b0000, 16'h6421, '0, 4'b0011, 4'h1, 4'h2, 0, 0, 0, 0, 4'b1100,
                    {32'hA0000006, 32'hA0000004, 32'h0, 32'h0});
        tbl[7]  = v(1, 4'b0110, 4'b0010, 16'h0550, {32'h0, 32'h0, 32'hDEADBEEF, 32'h0},
                    4'b0010, 4'h5, 4'h0, 1, 0, 32'hDEADBEEF, 0, 4'b0000, '0);
        tbl[8]  = v(0, 4'b0100, 4'b0000, 16'h0500, '0, 4'b0100, 4'h5, 4'h0, 0, 0, 0, 0, 4'b0000, '0);
        tbl[9]  = v(0, 4'b0000, 4'b0000, 16'h0000, '0, 4'b0000, 4'h0, 4'h0, 0, 0, 0, 0, 4'b0100,
                    {32'h0, 32'hDEADBEEF, 32'h0, 32'h0});
        tbl[10] = v(1, 4'b1001, 4'b0000, 16'h7007, '0, 4'b1001, 4'h7, 4'h7, 0, 0, 0, 0, 4'b0000, '0);
        tbl[11] = v(0, 4'b0000, 4'b0000, 16'h0000, '0, 4'b0000, 4'h0, 4'h0, 0, 0, 0, 0, 4'b1001,
                    {32'hA0000007, 32'h0, 32'h0, 32'hA0000007});

        req = '0; req_we = '0; req_addr = '0; req_wdata = '0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Directed table
        for (int r = 0; r < 12; r++) begin
            req = tbl[r].rq; req_we = tbl[r].we; req_addr = tbl[r].ad; req_wdata = tbl[r].wd;
            if (tbl[r].rst) begin
                rst_n = 1'b0;
                #4;
                chk("rst_gnt", gnt, 0);
                chk("rst_we", {we_a, we_b}, 0);
                chk("rst_rvalid", rvalid, 0);
                @(posedge clk); #1;
                rst_n = 1'b1;
            end
            #4;
            chk($sformatf("v%0d_gnt", r), gnt, tbl[r].g);
            chk($sformatf("v%0d_addr_a", r), addr_a, tbl[r].aa);
            chk($sformatf("v%0d_addr_b", r), addr_b, tbl[r].ab);
            chk($sformatf("v%0d_we", r), {we_a, we_b}, {tbl[r].wea, tbl[r].web});
            chk($sformatf("v%0d_data_a", r), data_a, tbl[r].da);
            chk($sformatf("v%0d_data_b", r), data_b, tbl[r].db);
            chk($sformatf("v%0d_rvalid", r), rvalid, tbl[r].rv);
            for (int i = 0; i < NR; i++)
                if (tbl[r].rv[i]) chk($sformatf("v%0d_rdata%0d", r, i), rdata[i*DW +: DW], tbl[r].rd[i*32 +: 32]);
            @(posedge clk); #1;
        end

        // Async reset 2ns after a read grant edge: rvalid dropped, pointer back to 0
        req = 4'b0100; req_we = '0; req_addr = 16'h0300; req_wdata = '0;
        @(posedge clk); #2;
        rst_n = 1'b0;
        req = 4'b1100; req_addr = 16'hBA00;
        #2;
        chk("mid_rst_rvalid", rvalid, 0);
        chk("mid_rst_gnt", gnt, 0);
        chk("mid_rst_we", {we_a, we_b}, 0);
        @(posedge clk); #1;
        chk("post_rst_rvalid", rvalid, 0);
        rst_n = 1'b1;
        #4;
        chk("post_rst_gnt", gnt, 4'b1100);
        chk("post_rst_addr_a", addr_a, 4'hA);
        chk("post_rst_addr_b", addr_b, 4'hB);
        @(posedge clk); #1;

        // Randomized run against the model
        req = '0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        ptr = 0;
        exp_rv = '0;
        for (int i = 0; i < 16; i++) mmem[i] = 32'hA000_0000 + 32'(i);
        mmem[3] = 32'h11111111; mmem[9] = 32'h22222222; mmem[5] = 32'hDEADBEEF;
        for (int i = 0; i < NR; i++) begin pv[i] = 0; exp_rd[i] = '0; end

        for (int cyc = 0; cyc < 600; cyc++) begin
            int q[$];
            int a_own, b_own;
            logic [3:0] m_gnt, nrv;
            logic [3:0] m_aa, m_ab;
            logic [31:0] m_da, m_db;
            logic m_wea, m_web;

            for (int i = 0; i < NR; i++) begin
                if (!pv[i] && $urandom_range(0, 2) != 0) begin
                    pv[i] = 1;
                    pw[i] = ($urandom_range(0, 2) == 0);
                    pa[i] = $urandom_range(0, 1) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
                    pd[i] = $urandom;
                end
                req[i] = pv[i];
                req_we[i] = pv[i] ? pw[i] : 1'($urandom_range(0, 1));
                req_addr[i*AW +: AW] = pv[i] ? pa[i] : 4'($urandom_range(0, 15));
                req_wdata[i*DW +: DW] = pv[i] ? pd[i] : $urandom;
            end
            #4;

            q = {};
            for (int k = 0; k < NR; k++) if (pv[(ptr + k) % NR]) q.push_back((ptr + k) % NR);
            a_own = -1; b_own = -1;
            if (q.size() >= 1) a_own = q[0];
            if (q.size() >= 2 && !(pa[q[1]] == pa[a_own] && (pw[a_own] || pw[q[1]]))) b_own = q[1];
            m_gnt = '0; m_aa = '0; m_ab = '0; m_da = '0; m_db = '0; m_wea = 0; m_web = 0;
            if (a_own >= 0) begin
                m_gnt[a_own] = 1; m_aa = pa[a_own]; m_da = pd[a_own]; m_wea = pw[a_own];
            end
            if (b_own >= 0) begin
                m_gnt[b_own] = 1; m_ab = pa[b_own]; m_db = pd[b_own]; m_web = pw[b_own];
            end

            chk("rnd_gnt", gnt, m_gnt);
            chk("rnd_addr_a", addr_a, m_aa);
            chk("rnd_addr_b", addr_b, m_ab);
            chk("rnd_data_a", data_a, m_da);
            chk("rnd_data_b", data_b, m_db);
            chk("rnd_we", {we_a, we_b}, {m_wea, m_web});
            chk("rnd_rvalid", rvalid, exp_rv);
            for (int i = 0; i < NR; i++)
                if (exp_rv[i]) chk($sformatf("rnd_rdata%0d", i), rdata[i*DW +: DW], exp_rd[i]);

            nrv = '0;
            if (a_own >= 0 && !pw[a_own]) begin nrv[a_own] = 1; exp_rd[a_own] = mmem[pa[a_own]]; end
            if (b_own >= 0 && !pw[b_own]) begin nrv[b_own] = 1; exp_rd[b_own] = mmem[pa[b_own]]; end
            if (a_own >= 0 && pw[a_own]) mmem[pa[a_own]] = pd[a_own];
            if (b_own >= 0 && pw[b_own]) mmem[pa[b_own]] = pd[b_own];
            exp_rv = nrv;
            if (b_own >= 0) ptr = (b_own + 1) % NR;
            else if (a_own >= 0) ptr = (a_own + 1) % NR;

            @(posedge clk); #1;
            if (a_own >= 0) pv[a_own] = 0;
            if (b_own >= 0) pv[b_own] = 0;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Shares the two-port sram (DATA_WIDTH/ADDR_WIDTH parameterised, 1-cycle registered read) among NUM_REQ requesters.
- Each cycle it grants up to two requests, in round-robin order. The first grant goes to port A and the second to port B.
- Read data is returned to the owning requester one cycle after grant.
- It sits between the memory controller clients and the sram instance. It blocks same-address hazards between the two ports.

Parameters:
DATA_WIDTH, 32, sram word width
ADDR_WIDTH, 4, sram address width (depth 2**ADDR_WIDTH)
NUM_REQ, 4, number of requesters (2..8)

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
req  in  NUM_REQ  request valid per requester; held until gnt
req_we  in  NUM_REQ  1=write, 0=read, per requester
req_addr  in  NUM_REQ*ADDR_WIDTH  address, requester i at slice i
req_wdata  in  NUM_REQ*DATA_WIDTH  write data, slice i
gnt  out  NUM_REQ  combinational grant; request consumed at this rising edge
rvalid  out  NUM_REQ  registered, read data valid for requester i
rdata  out  NUM_REQ*DATA_WIDTH  read data, slice i, valid when rvalid[i]
addr_a, addr_b  out  ADDR_WIDTH  to sram ports A/B
data_a, data_b  out  DATA_WIDTH  to sram write data
we_a, we_b  out  1  to sram write enables
q_a, q_b  in  DATA_WIDTH  sram read data (valid 1 cycle after address)

Behaviour:
- Reset (async, rst_n=0):
  - rr_ptr=0; rvalid=0; owner_a/owner_b valid bits cleared.
  - While rst_n=0, gnt=0 and we_a=we_b=0 (combinationally forced).
- Arbitration (combinational, every cycle):
  - Scan requesters in order rr_ptr, rr_ptr+1, ... wrapping mod NUM_REQ.
  - First requester found with req=1 is W1. It gets port A.
  - Next requester after W1 with req=1 is candidate W2. It gets port B unless hazard.
  - Hazard: addr(W2)==addr(W1) and (we(W1) or we(W2)). Then W2 is not granted this cycle and port B idles. There is no search for a third requester.
  - Two reads of the same address are both granted.
  - gnt[W1], gnt[W2] asserted; all others 0.
- Port drive:
  - Granted port: addr, data and we are taken from the owner.
  - Idle port: addr=0, data=0, we=0.
- Pointer update (on each edge where at least one grant occurs):
  - rr_ptr <= (index of last granted requester + 1) mod NUM_REQ.
  - No grant: rr_ptr holds.
- Read return:
  - At the grant edge, register owner_a/owner_b (index + read flag).
  - Next cycle, rvalid[owner]=1 for each read owner, for exactly one cycle.
  - rdata slice of owner_a = q_a and owner_b = q_b (muxed from registered owner). Non-owned rdata slices = 0.
  - Writes produce no rvalid.
- Throughput and latency:
  - A requester may re-request on the cycle after gnt. Back-to-back accesses are allowed, giving one access per requester per cycle maximum.
  - Read latency is exactly 1 cycle from gnt edge to rvalid.
- Ordering:
  - Same-address write then read by a different requester in a later cycle returns the new data.
  - Same-cycle same-address write/read never happens (hazard rule).
- Reset mid-operation: any pending rvalid is dropped. The pointer restarts at 0.
- Unrequested we/addr/wdata are don't-care and must not affect grants.

Test Plan:
- Reset then idle: rst_n low, all req=0 -> gnt=0, rvalid=0, we_a=we_b=0, addr_a=addr_b=0.
- Two writes: req0 write addr 3 data 0x11111111 and req2 write addr 9 data 0x22222222 in the same cycle.
  - Required: gnt=0101, port A gets addr 3, port B gets addr 9.
  - Then both read back: next cycle rvalid=0101 with the correct data.
- Round-robin fairness: all four requesters continuously request reads of distinct addresses.
  - Required: grant pairs {0,1},{2,3},{0,1}... and rr_ptr sequence 0,2,0.
  - No requester waits more than 1 cycle.
- Write hazard: req1 write addr 5 0xDEADBEEF and req2 read addr 5 in the same cycle (rr_ptr=0).
  - Required: gnt=0010 and we_b=0.
  - Next cycle gnt=0100; the following cycle rvalid[2]=1 with rdata slice 2 =0xDEADBEEF.
- Read-read same address: req0 and req3 read addr 7 together -> gnt=1001 and both rvalid next cycle with identical data.
- Async reset mid-read: assert rst_n low 2ns after a read grant edge.
  - Required: rvalid stays 0 and rr_ptr=0.
  - After release, the first grant goes to the lowest-index requester.
